// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two common data bus lanes between the result producers.
// Producer 0 is the ALU, 1 the branch unit, 2 load/store and 3 mul/div.
//
// Each cycle up to two requesting producers are granted. A round-robin scan picks them.
// Their payloads are captured into per-lane registers, and the bus is valid on the next cycle.
//
// Ports:
//   i_clock, i_reset      clock; synchronous active-high reset
//   i_clear               pipeline flush: suppresses grants and drops the pending bus outputs
//   i_req                 per-producer result-valid request
//   i_result, i_jmp_address, i_tag, i_arn
//                         packed producer payloads, slice k belongs to producer k
//   o_grant               combinational grant, at most two bits set
//   o_cdb_valid           per-lane bus valid, lane 0 in bit 0
//   o_cdb_result, o_cdb_jmp_address, o_cdb_tag, o_cdb_arn
//                         registered lane payloads, lane 0 in the low slice
//   o_rr_ptr              current round-robin scan start, for debug
module cdb_arbiter #(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH    = 6,
  parameter int unsigned REG_WIDTH    = 6
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_clear,
  input  logic [REQUESTERS-1:0]             i_req,
  input  logic [REQUESTERS*RESULT_WIDTH-1:0] i_result,
  input  logic [REQUESTERS*RESULT_WIDTH-1:0] i_jmp_address,
  input  logic [REQUESTERS*TAG_WIDTH-1:0]   i_tag,
  input  logic [REQUESTERS*REG_WIDTH-1:0]   i_arn,
  output logic [REQUESTERS-1:0]             o_grant,
  output logic [1:0]                        o_cdb_valid,
  output logic [2*RESULT_WIDTH-1:0]         o_cdb_result,
  output logic [2*RESULT_WIDTH-1:0]         o_cdb_jmp_address,
  output logic [2*TAG_WIDTH-1:0]            o_cdb_tag,
  output logic [2*REG_WIDTH-1:0]            o_cdb_arn,
  output logic [$clog2(REQUESTERS)-1:0]     o_rr_ptr
);

  localparam int unsigned PTR_WIDTH = $clog2(REQUESTERS);

  logic [PTR_WIDTH-1:0]      rr_ptr_q;
  logic [PTR_WIDTH-1:0]      scan_idx;
  logic [PTR_WIDTH-1:0]      idx0;
  logic [PTR_WIDTH-1:0]      idx1;
  logic [PTR_WIDTH-1:0]      last_idx;
  logic [PTR_WIDTH-1:0]      ptr_next;
  logic                      found0;
  logic                      found1;
  logic                      grant_en;
  logic                      take0;
  logic                      take1;

  logic [1:0]                valid_q;
  logic [2*RESULT_WIDTH-1:0] result_q;
  logic [2*RESULT_WIDTH-1:0] jmp_q;
  logic [2*TAG_WIDTH-1:0]    tag_q;
  logic [2*REG_WIDTH-1:0]    arn_q;

  // Scan from rr_ptr_q upwards modulo REQUESTERS. The first two requesters found win lanes 0 and 1.
  always_comb begin
    found0   = 1'b0;
    found1   = 1'b0;
    idx0     = '0;
    idx1     = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      scan_idx = PTR_WIDTH'((32'(rr_ptr_q) + i) % REQUESTERS);
      if (i_req[scan_idx]) begin
        if (!found0) begin
          found0 = 1'b1;
          idx0   = scan_idx;
        end else if (!found1) begin
          found1 = 1'b1;
          idx1   = scan_idx;
        end
      end
    end
  end

  assign grant_en = !i_reset && !i_clear;
  assign take0    = grant_en && found0;
  assign take1    = grant_en && found1;

  // Resume the scan just after the last producer served.
  assign last_idx = found1 ? idx1 : idx0;
  assign ptr_next = PTR_WIDTH'((32'(last_idx) + 32'd1) % REQUESTERS);

  always_comb begin
    o_grant = '0;
    if (take0) o_grant[idx0] = 1'b1;
    if (take1) o_grant[idx1] = 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q  <= '0;
      result_q <= '0;
      jmp_q    <= '0;
      tag_q    <= '0;
      arn_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q <= {take1, take0};
      // Idle lanes keep their old payload; only the valid bit matters to consumers.
      if (take0) begin
        result_q[0 +: RESULT_WIDTH] <= i_result[idx0*RESULT_WIDTH +: RESULT_WIDTH];
        jmp_q[0 +: RESULT_WIDTH]    <= i_jmp_address[idx0*RESULT_WIDTH +: RESULT_WIDTH];
        tag_q[0 +: TAG_WIDTH]       <= i_tag[idx0*TAG_WIDTH +: TAG_WIDTH];
        arn_q[0 +: REG_WIDTH]       <= i_arn[idx0*REG_WIDTH +: REG_WIDTH];
        rr_ptr_q                    <= ptr_next;
      end
      if (take1) begin
        result_q[RESULT_WIDTH +: RESULT_WIDTH] <= i_result[idx1*RESULT_WIDTH +: RESULT_WIDTH];
        jmp_q[RESULT_WIDTH +: RESULT_WIDTH]    <= i_jmp_address[idx1*RESULT_WIDTH +: RESULT_WIDTH];
        tag_q[TAG_WIDTH +: TAG_WIDTH]          <= i_tag[idx1*TAG_WIDTH +: TAG_WIDTH];
        arn_q[REG_WIDTH +: REG_WIDTH]          <= i_arn[idx1*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign o_cdb_valid       = valid_q;
  assign o_cdb_result      = result_q;
  assign o_cdb_jmp_address = jmp_q;
  assign o_cdb_tag         = tag_q;
  assign o_cdb_arn         = arn_q;
  assign o_rr_ptr          = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int R  = 4;
  localparam int RW = 32;
  localparam int TW = 6;
  localparam int AW = 6;
  localparam int LW = 2 * RW + TW + AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [R-1:0]    req;
  logic [R*RW-1:0] result_v;
  logic [R*RW-1:0] jmp_v;
  logic [R*TW-1:0] tag_v;
  logic [R*AW-1:0] arn_v;
  logic [R-1:0]    grant;
  logic [1:0]      cdb_valid;
  logic [2*RW-1:0] cdb_result;
  logic [2*RW-1:0] cdb_jmp;
  logic [2*TW-1:0] cdb_tag;
  logic [2*AW-1:0] cdb_arn;
  logic [1:0]      rr_ptr;

  // Producer-side payloads.
  logic [RW-1:0] res[R];
  logic [RW-1:0] jmp[R];
  logic [TW-1:0] tag[R];
  logic [AW-1:0] arn[R];

  // Reference model of the bus registers.
  logic [1:0]    m_valid;
  logic [LW-1:0] m_word[2];
  int            m_ptr;
  int            last_g0;
  int            last_g1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .REQUESTERS  (R),
    .RESULT_WIDTH(RW),
    .TAG_WIDTH   (TW),
    .REG_WIDTH   (AW)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_clear          (clr),
    .i_req            (req),
    .i_result         (result_v),
    .i_jmp_address    (jmp_v),
    .i_tag            (tag_v),
    .i_arn            (arn_v),
    .o_grant          (grant),
    .o_cdb_valid      (cdb_valid),
    .o_cdb_result     (cdb_result),
    .o_cdb_jmp_address(cdb_jmp),
    .o_cdb_tag        (cdb_tag),
    .o_cdb_arn        (cdb_arn),
    .o_rr_ptr         (rr_ptr)
  );

  task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] pword(input int k);
    return {res[k], jmp[k], tag[k], arn[k]};
  endfunction

  function automatic logic [LW-1:0] dut_lane(input int l);
    return {cdb_result[l*RW +: RW], cdb_jmp[l*RW +: RW], cdb_tag[l*TW +: TW],
            cdb_arn[l*AW +: AW]};
  endfunction

  task automatic pack();
    for (int k = 0; k < R; k++) begin
      result_v[k*RW +: RW] = res[k];
      jmp_v[k*RW +: RW]    = jmp[k];
      tag_v[k*TW +: TW]    = tag[k];
      arn_v[k*AW +: AW]    = arn[k];
    end
  endtask

  // Requesters listed in round-robin order from ptr; the first two win.
  task automatic model_grant(input logic [R-1:0] rq, input int ptr, output int g0, output int g1);
    int q[$];
    for (int i = 0; i < R; i++)
      if (rq[(ptr + i) % R]) q.push_back((ptr + i) % R);
    g0 = (q.size() > 0) ? q[0] : -1;
    g1 = (q.size() > 1) ? q[1] : -1;
  endtask

  // One clock cycle: check the DUT against the model, then advance both across the edge.
  task automatic cycle();
    int g0;
    int g1;
    logic [R-1:0] exp_g;
    pack();
    #2;
    if (rst || clr) begin
      g0 = -1;
      g1 = -1;
    end else begin
      model_grant(req, m_ptr, g0, g1);
    end
    exp_g = '0;
    if (g0 >= 0) exp_g[g0] = 1'b1;
    if (g1 >= 0) exp_g[g1] = 1'b1;
    check_eq("grant", grant, exp_g);
    check_eq("grant_count_le2", ($countones(grant) <= 2), 1);
    check_eq("cdb_valid", cdb_valid, m_valid);
    check_eq("rr_ptr", rr_ptr, m_ptr);
    if (m_valid[0]) check_eq("lane0_payload", dut_lane(0), m_word[0]);
    if (m_valid[1]) check_eq("lane1_payload", dut_lane(1), m_word[1]);
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    if (rst) begin
      m_valid   = '0;
      m_ptr     = 0;
      m_word[0] = '0;
      m_word[1] = '0;
    end else if (clr) begin
      m_valid = '0;
    end else begin
      m_valid = {(g1 >= 0), (g0 >= 0)};
      if (g0 >= 0) m_word[0] = pword(g0);
      if (g1 >= 0) m_word[1] = pword(g1);
      if (g1 >= 0) m_ptr = (g1 + 1) % R;
      else if (g0 >= 0) m_ptr = (g0 + 1) % R;
    end
    #1;
  endtask

  task automatic pre_grant(input string name, input logic [R-1:0] exp);
    pack();
    #1;
    check_eq(name, grant, exp);
  endtask

  logic [R-1:0] rot_grant[4];
  int           rot_ptr[4];
  bit           pend[R];
  int           waited[R];

  initial begin
    rot_grant = '{4'b1100, 4'b0011, 4'b1100, 4'b0011};
    rot_ptr   = '{0, 2, 0, 2};
    m_valid   = '0;
    m_ptr     = 0;
    m_word[0] = '0;
    m_word[1] = '0;
    for (int k = 0; k < R; k++) begin
      res[k] = 32'h1000_0000 + k;
      jmp[k] = 32'h2000_0000 + k;
      tag[k] = TW'(k + 8);
      arn[k] = AW'(k + 16);
    end
    tag[1] = 6'h2A;
    res[3] = 32'hDEADBEEF;

    // Reset for two cycles with everyone requesting.
    rst = 1'b1;
    clr = 1'b0;
    req = 4'b1111;
    pack();
    @(posedge clk);
    #1;
    pre_grant("reset_grant", 4'b0000);
    cycle();
    check_eq("reset_valid", cdb_valid, 2'b00);
    check_eq("reset_ptr", rr_ptr, 0);
    check_eq("reset_result", cdb_result, 0);
    check_eq("reset_tag", cdb_tag, 0);

    rst = 1'b0;
    pre_grant("first_grant", 4'b0011);
    cycle();
    check_eq("first_valid", cdb_valid, 2'b11);
    check_eq("first_lane0", cdb_result[0 +: RW], 32'h1000_0000);
    check_eq("first_lane1", cdb_result[RW +: RW], 32'h1000_0001);
    check_eq("first_ptr", rr_ptr, 2);

    for (int c = 0; c < 4; c++) begin
      pre_grant("rotate_grant", rot_grant[c]);
      cycle();
      check_eq("rotate_ptr", rr_ptr, rot_ptr[c]);
    end

    // Single requester behind the pointer.
    req = 4'b0010;
    pre_grant("single_grant", 4'b0010);
    cycle();
    check_eq("single_valid", cdb_valid, 2'b01);
    check_eq("single_tag", cdb_tag[0 +: TW], 6'h2A);
    check_eq("single_ptr", rr_ptr, 2);

    req = 4'b0100;
    cycle();
    check_eq("to_ptr3", rr_ptr, 3);

    // Wrap-around pair 3 then 0.
    req = 4'b1001;
    pre_grant("wrap_grant", 4'b1001);
    cycle();
    check_eq("wrap_ptr", rr_ptr, 1);
    check_eq("wrap_lane0", cdb_result[0 +: RW], 32'hDEADBEEF);
    check_eq("wrap_lane1", cdb_result[RW +: RW], 32'h1000_0000);

    // Flush with both lanes busy on the bus.
    req = 4'b1111;
    cycle();
    req = 4'b0110;
    clr = 1'b1;
    pre_grant("flush_grant", 4'b0000);
    check_eq("flush_bus_still_valid", cdb_valid, 2'b11);
    cycle();
    check_eq("flush_valid", cdb_valid, 2'b00);
    check_eq("flush_ptr", rr_ptr, 3);
    clr = 1'b0;
    pre_grant("rerequest_grant", 4'b0110);
    cycle();
    check_eq("rerequest_valid", cdb_valid, 2'b11);

    // Randomized producers that hold their request until granted.
    for (int k = 0; k < R; k++) begin
      pend[k]   = 1'b0;
      waited[k] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(499) == 0);
      clr = ($urandom_range(49) == 0);
      for (int k = 0; k < R; k++) begin
        if (!pend[k] && $urandom_range(99) < 60) begin
          pend[k]   = 1'b1;
          waited[k] = 0;
          res[k]    = $urandom;
          jmp[k]    = $urandom;
          tag[k]    = TW'($urandom);
          arn[k]    = AW'($urandom);
        end else if (pend[k] && $urandom_range(31) == 0) begin
          pend[k] = 1'b0;
        end
        req[k] = pend[k];
      end
      cycle();
      for (int k = 0; k < R; k++) begin
        if (pend[k]) begin
          if (rst || clr || last_g0 == k || last_g1 == k) begin
            pend[k] = 1'b0;
          end else begin
            waited[k]++;
            check_eq("starvation", (waited[k] >= 2), 0);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
